// File: rtl/spi_byte_sequencer.sv
// Host-side byte sequencer for an SPI master core: a TX FIFO feeds one master transfer per byte,
// and each returned byte lands in an RX FIFO. A watchdog aborts transfers that never complete.
module spi_byte_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [7:0]             wr_data,
  output logic                   wr_ready,
  output logic                   rd_valid,
  output logic [7:0]             rd_data,
  input  logic                   rd_ready,
  output logic                   spi_start,
  output logic [7:0]             spi_tx_data,
  input  logic                   spi_busy,
  input  logic                   spi_done,
  input  logic [7:0]             spi_rx_data,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic                   timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(TIMEOUT);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [LW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [LW-1:0] tx_level_nxt, rx_level_nxt;
  logic [LW:0]   rx_committed;
  logic [0:0]    state;
  logic [WW-1:0] wd;
  logic          vld_p1;
  logic [7:0]    rx_data_p1;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          launch, xfer_done, wd_expire;

  assign tx_level = tx_wptr - tx_rptr;
  assign rx_level = rx_wptr - rx_rptr;
  assign rd_data  = rx_mem[rx_rptr[AW-1:0]];

  assign tx_push = wr_valid & wr_ready;
  assign rx_pop  = rd_valid & rd_ready;
  assign rx_push = vld_p1;

  // A returned byte still in the capture stage already owns an RX slot.
  assign rx_committed = {1'b0, rx_level} + {{LW{1'b0}}, vld_p1};

  assign launch    = (state == IDLE) && (tx_level != '0) && !spi_busy &&
                     (rx_committed < (LW+1)'(DEPTH));
  assign tx_pop    = launch;
  assign xfer_done = (state == XFER) && spi_done;
  assign wd_expire = (state == XFER) && !spi_done && (wd == WW'(TIMEOUT - 1));

  assign tx_level_nxt = tx_level + LW'(tx_push) - LW'(tx_pop);
  assign rx_level_nxt = rx_level + LW'(rx_push) - LW'(rx_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr     <= '0;
      tx_rptr     <= '0;
      rx_wptr     <= '0;
      rx_rptr     <= '0;
      wr_ready    <= 1'b1;
      rd_valid    <= 1'b0;
      spi_start   <= 1'b0;
      spi_tx_data <= '0;
      timeout_err <= 1'b0;
      state       <= IDLE;
      wd          <= '0;
      vld_p1      <= 1'b0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + LW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + LW'(1);
      if (rx_push) rx_wptr <= rx_wptr + LW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + LW'(1);
      wr_ready  <= (tx_level_nxt != LW'(DEPTH));
      rd_valid  <= (rx_level_nxt != '0);
      spi_start <= launch;
      vld_p1    <= xfer_done;
      if (launch) spi_tx_data <= tx_mem[tx_rptr[AW-1:0]];
      case (state)
        IDLE: begin
          if (launch) begin
            state <= XFER;
            wd    <= '0;
          end
        end
        XFER: begin
          if (xfer_done) begin
            state <= IDLE;
          end else if (wd_expire) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            wd <= wd + WW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: returned byte is captured, then committed to the RX FIFO one edge later.
  always_ff @(posedge clk) begin
    if (tx_push)   tx_mem[tx_wptr[AW-1:0]] <= wr_data;
    if (rx_push)   rx_mem[rx_wptr[AW-1:0]] <= rx_data_p1;
    if (xfer_done) rx_data_p1 <= spi_rx_data;
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Bench for spi_byte_sequencer: queue-based reference model checked every cycle, a behavioural
// SPI master with configurable latency/reply, directed scenarios followed by a randomized run.
module tb_spi_byte_sequencer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 40;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          wr_ready;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          rd_ready = 1'b0;
  logic          spi_start;
  logic [7:0]    spi_tx_data;
  logic          spi_busy;
  logic          spi_done = 1'b0;
  logic [7:0]    spi_rx_data = 8'h00;
  logic [LW-1:0] tx_level;
  logic [LW-1:0] rx_level;
  logic          timeout_err;

  always #5 clk = ~clk;

  spi_byte_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_busy(spi_busy),
    .spi_done(spi_done), .spi_rx_data(spi_rx_data),
    .tx_level(tx_level), .rx_level(rx_level), .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle", tag, got, exp);
    end
  endtask

  // Behavioural SPI master
  logic       m_busy = 1'b0;
  logic       force_busy = 1'b0;
  logic       m_rand = 1'b0;
  int         m_delay = 9;
  int         m_reply_mode = 1;
  logic [7:0] m_fixed = 8'h3C;
  logic [7:0] m_tx = 8'h00;
  int         mcnt = 0;
  int         hcnt = 0;
  int         md;

  assign spi_busy = m_busy | force_busy;

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(39, 0));
    if (r == 0) return 0;
    if (r == 1) return TIMEOUT - 1;
    if (r == 2) return TIMEOUT;
    if (r == 3) return TIMEOUT + 1;
    return 1 + int'($urandom_range(5, 0));
  endfunction

  task automatic fire();
    spi_done = 1'b1;
    m_busy   = 1'b0;
    if (m_reply_mode == 0)      spi_rx_data = m_tx;
    else if (m_reply_mode == 1) spi_rx_data = m_fixed;
    else                        spi_rx_data = 8'($urandom);
  endtask

  always @(negedge clk) begin
    spi_done = 1'b0;
    if (spi_start === 1'b1) begin
      m_tx = spi_tx_data;
      md   = m_rand ? pick_delay() : m_delay;
      if (md == 0) begin
        m_busy = 1'b1;
        hcnt   = 3;
        mcnt   = 0;
      end else if (md == 1) begin
        fire();
      end else begin
        mcnt   = md - 1;
        m_busy = 1'b1;
      end
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) fire();
    end else if (hcnt > 0) begin
      hcnt--;
      if (hcnt == 0) m_busy = 1'b0;
    end else if (m_rand && !m_busy && $urandom_range(19, 0) == 0) begin
      spi_done    = 1'b1;
      spi_rx_data = 8'($urandom);
    end
  end

  // Reference model: queues for committed bytes, a time stamp for the in-flight transfer
  logic [7:0] m_txq[$];
  logic [7:0] m_rxq[$];
  bit         m_inflight = 0;
  int         m_launch_cyc = 0;
  bit         m_pend = 0;
  logic [7:0] m_pend_byte = 8'h00;
  bit         m_start = 0;
  bit         m_wr_ready = 1;
  bit         m_rd_valid = 0;
  bit         m_err = 0;
  logic [7:0] m_tx_byte = 8'h00;
  bit         s_push, s_pop, s_launch, s_done, s_expire;
  int         cyc = 0;
  int         n_starts = 0;
  int         t_start = 0;
  int         t_err = 0;
  bit         prev_err = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_txq.delete();
      m_rxq.delete();
      m_inflight = 0;
      m_pend     = 0;
      m_start    = 0;
      m_wr_ready = 1;
      m_rd_valid = 0;
      m_err      = 0;
      m_tx_byte  = 8'h00;
    end else begin
      s_push   = wr_valid && m_wr_ready;
      s_pop    = m_rd_valid && rd_ready;
      s_launch = !m_inflight && m_txq.size() != 0 && !spi_busy &&
                 (m_rxq.size() + int'(m_pend)) < DEPTH;
      s_done   = m_inflight && spi_done;
      s_expire = m_inflight && !spi_done && (cyc - m_launch_cyc == TIMEOUT);
      if (s_pop) void'(m_rxq.pop_front());
      if (m_pend) m_rxq.push_back(m_pend_byte);
      m_pend = s_done;
      if (s_done) m_pend_byte = spi_rx_data;
      if (s_launch) begin
        m_tx_byte    = m_txq.pop_front();
        m_inflight   = 1;
        m_launch_cyc = cyc;
      end else if (s_done || s_expire) begin
        m_inflight = 0;
      end
      if (s_expire) m_err = 1;
      if (s_push) m_txq.push_back(wr_data);
      m_start    = s_launch;
      m_wr_ready = m_txq.size() < DEPTH;
      m_rd_valid = m_rxq.size() != 0;
    end
    #1;
    check("spi_start", spi_start, m_start);
    check("spi_tx_data", spi_tx_data, m_tx_byte);
    check("wr_ready", wr_ready, m_wr_ready);
    check("rd_valid", rd_valid, m_rd_valid);
    if (m_rd_valid) check("rd_data", rd_data, m_rxq[0]);
    check("tx_level", tx_level, m_txq.size());
    check("rx_level", rx_level, m_rxq.size());
    check("timeout_err", timeout_err, m_err);
    if (spi_start === 1'b1) begin
      n_starts++;
      t_start = cyc;
    end
    if (timeout_err === 1'b1 && !prev_err) t_err = cyc;
    prev_err = (timeout_err === 1'b1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    for (int i = 0; i < 200 && !wr_ready; i++) @(negedge clk);
    check("push_ready", wr_ready, 1'b1);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  int s0;

  initial begin
    idle(3);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_start", spi_start, 1'b0);
    check("rst_tx_data", spi_tx_data, 8'h00);
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_err", timeout_err, 1'b0);
    rst = 1'b0;

    // 1) single transfer, fixed reply
    s0 = n_starts;
    push(8'hA5);
    for (int i = 0; i < 40 && !rd_valid; i++) @(negedge clk);
    check("s1_rd_valid", rd_valid, 1'b1);
    check("s1_rd_data", rd_data, 8'h3C);
    check("s1_tx_data", spi_tx_data, 8'hA5);
    check("s1_tx_level", tx_level, 0);
    check("s1_rx_level", rx_level, 1);
    check("s1_starts", n_starts - s0, 1);
    pop_one();

    // 2) RX fills, launch blocked until space appears
    m_reply_mode = 0;
    m_delay      = 3;
    for (int i = 1; i <= 8; i++) push(8'(i));
    for (int i = 0; i < 200 && rx_level != 8; i++) @(negedge clk);
    check("s2_rx_full", rx_level, 8);
    s0 = n_starts;
    push(8'h09);
    idle(20);
    check("s2_no_launch", n_starts - s0, 0);
    check("s2_tx_held", tx_level, 1);
    check("s2_head", rd_data, 8'h01);
    pop_one();
    for (int i = 0; i < 30 && rx_level != 8; i++) @(negedge clk);
    check("s2_relaunch", n_starts - s0, 1);
    for (int i = 2; i <= 9; i++) begin
      check("s2_order_valid", rd_valid, 1'b1);
      check("s2_order", rd_data, 8'(i));
      pop_one();
    end
    check("s2_drained", rd_valid, 1'b0);

    // 3) TX full while master busy; release busy while a write is held
    force_busy = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    check("s3_full_ready", wr_ready, 1'b0);
    check("s3_full_level", tx_level, 8);
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    @(negedge clk);
    check("s3_reject", tx_level, 8);
    force_busy = 1'b0;
    check("s3_ready_at_pop", wr_ready, 1'b0);
    @(negedge clk);
    check("s3_pop_level", tx_level, 7);
    check("s3_pop_start", spi_start, 1'b1);
    check("s3_reopen", wr_ready, 1'b1);
    @(negedge clk);
    wr_valid = 1'b0;
    check("s3_refill", tx_level, 8);
    rd_ready = 1'b1;
    idle(150);
    rd_ready = 1'b0;
    check("s3_tx_drained", tx_level, 0);
    check("s3_rx_drained", rx_level, 0);

    // 4) master never completes
    m_delay = 0;
    push(8'h55);
    for (int i = 0; i < TIMEOUT + 20 && !timeout_err; i++) @(negedge clk);
    check("s4_err", timeout_err, 1'b1);
    check("s4_abort_time", t_err - t_start, TIMEOUT);
    check("s4_no_rx", rx_level, 0);
    m_delay = 3;
    push(8'h66);
    for (int i = 0; i < 30 && !rd_valid; i++) @(negedge clk);
    check("s4_next_rd", rd_data, 8'h66);
    check("s4_err_sticky", timeout_err, 1'b1);
    pop_one();

    // 5) reset mid-transfer, late done
    m_delay = 10;
    push(8'hC3);
    for (int i = 0; i < 20 && !spi_start; i++) @(negedge clk);
    check("s5_started", spi_start, 1'b1);
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s0 = n_starts;
    idle(15);
    check("s5_rx_level", rx_level, 0);
    check("s5_rd_valid", rd_valid, 1'b0);
    check("s5_tx_level", tx_level, 0);
    check("s5_err", timeout_err, 1'b0);
    check("s5_tx_data", spi_tx_data, 8'h00);
    check("s5_wr_ready", wr_ready, 1'b1);
    check("s5_no_start", n_starts - s0, 0);

    // 6) done lands on the timeout edge
    m_delay = TIMEOUT;
    push(8'h77);
    for (int i = 0; i < TIMEOUT + 20 && !rd_valid; i++) @(negedge clk);
    check("s6_rd", rd_data, 8'h77);
    check("s6_err", timeout_err, 1'b0);
    pop_one();

    // randomized traffic
    m_rand       = 1'b1;
    m_reply_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      wr_valid   = $urandom_range(1, 0) == 1;
      wr_data    = 8'($urandom);
      rd_ready   = $urandom_range(2, 0) != 0;
      force_busy = $urandom_range(15, 0) == 0;
      @(negedge clk);
    end
    wr_valid   = 1'b0;
    force_busy = 1'b0;
    m_rand     = 1'b0;
    m_delay    = 3;
    rd_ready   = 1'b1;
    idle(500);
    check("end_tx_level", tx_level, 0);
    check("end_rx_level", rx_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL time_limit: got expired expected completion");
    $fatal(1, "time limit");
  end

endmodule
